hex_display_mux: RTL and testbench

HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

---
 rtl/hex_display_mux.sv | 176 +++++++++++++++++
 tb/tb_hex_display_mux.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hex_display_mux.sv
// Multiplexed 7-segment hex display driver with PWM brightness, leading-zero
// blanking and frame-synchronous (tear-free) update of the displayed value.

module hex_display_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg_on
);
  logic [6:0] pat;

  // Active-high {G,F,E,D,C,B,A}
  always_comb begin
    pat = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

  assign seg_on = blank ? 7'h00 : pat;
endmodule

module hex_display_mux #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DIV_BITS       = 10,
  parameter int unsigned PWM_BITS       = 4,
  parameter bit          EN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     ds_en,
  output logic [6:0]            ds_seg,
  output logic                  ds_dp,
  output logic                  frame_done
);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_BITS-1:0] PRE_MAX = '1;
  localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]   EN_IDLE  = EN_ACTIVE_LOW  ? '1 : '0;
  localparam logic [6:0]          SEG_IDLE = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic                DP_IDLE  = SEG_ACTIVE_LOW;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] nib;
    logic [DIGITS-1:0]      dp;
  } disp_t;

  logic [DIV_BITS-1:0] pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  disp_t               disp_q, disp_d;
  disp_t               stg_q, stg_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   ds_en_q, ds_en_d;
  logic [6:0]          ds_seg_q, ds_seg_d;
  logic                ds_dp_q, ds_dp_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end, boundary;
  disp_t               load_val;

  assign slot_end = (pre_q == PRE_MAX);
  assign boundary = slot_end && (idx_q == IDX_MAX);
  assign load_val = '{nib: data, dp: dp};

  // Scan counters and staged/displayed register update
  always_comb begin
    pre_d     = pre_q + 1'b1;
    idx_d     = idx_q;
    disp_d    = disp_q;
    stg_d     = stg_q;
    pending_d = pending_q;
    if (slot_end) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    if (boundary) begin
      if (load) begin
        disp_d    = load_val;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = stg_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      stg_d     = load_val;
      pending_d = 1'b1;
    end
  end

  // Leading-zero run from the most significant digit down; digit 0 never blanks
  logic [DIGITS-1:0] blank_vec;
  always_comb begin
    logic zero_run;
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run && (disp_q.nib[i] == 4'h0);
      blank_vec[i] = blank_lz && zero_run;
    end
  end

  logic [DIGITS-1:0][6:0] lane_seg;
  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    hex_display_lane u_lane (
      .nib    (disp_q.nib[g]),
      .blank  (blank_vec[g]),
      .seg_on (lane_seg[g])
    );
  end

  logic [PWM_BITS-1:0] duty_top;
  logic                lit;
  logic [DIGITS-1:0]   en_ah;
  logic [6:0]          seg_ah;
  logic                dp_ah;

  assign duty_top = pre_q[DIV_BITS-1 -: PWM_BITS];
  assign lit      = (&brightness) || (duty_top < brightness);

  always_comb begin
    en_ah        = lit ? (DIGITS'(1) << idx_q) : '0;
    seg_ah       = lit ? lane_seg[idx_q] : 7'h00;
    dp_ah        = lit && disp_q.dp[idx_q];
    ds_en_d      = EN_ACTIVE_LOW  ? ~en_ah  : en_ah;
    ds_seg_d     = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
    ds_dp_d      = SEG_ACTIVE_LOW ? ~dp_ah  : dp_ah;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      stg_q        <= '0;
      pending_q    <= 1'b0;
      ds_en_q      <= EN_IDLE;
      ds_seg_q     <= SEG_IDLE;
      ds_dp_q      <= DP_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      stg_q        <= stg_d;
      pending_q    <= pending_d;
      ds_en_q      <= ds_en_d;
      ds_seg_q     <= ds_seg_d;
      ds_dp_q      <= ds_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ds_en      = ds_en_q;
  assign ds_seg     = ds_seg_q;
  assign ds_dp      = ds_dp_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux at 4 digits, 16-clock slots, active-low outputs.

module tb_hex_display_mux;
  localparam int DIGITS = 4, DIV_BITS = 4, PWM_BITS = 4;

  logic        clk = 1'b0;
  logic        rst, load, blank_lz, ds_dp, frame_done;
  logic [15:0] data;
  logic [3:0]  dp, brightness, ds_en;
  logic [6:0]  ds_seg;

  int n_chk = 0, n_fail = 0, cyc = 0, lit_cnt = 0;

  always #5 clk = ~clk;

  hex_display_mux #(
    .DIGITS(DIGITS), .DIV_BITS(DIV_BITS), .PWM_BITS(PWM_BITS),
    .EN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load),
    .blank_lz(blank_lz), .brightness(brightness),
    .ds_en(ds_en), .ds_seg(ds_seg), .ds_dp(ds_dp), .frame_done(frame_done)
  );

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h3F; 4'h1: hex_seg = 7'h06; 4'h2: hex_seg = 7'h5B; 4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66; 4'h5: hex_seg = 7'h6D; 4'h6: hex_seg = 7'h7D; 4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F; 4'h9: hex_seg = 7'h6F; 4'hA: hex_seg = 7'h77; 4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39; 4'hD: hex_seg = 7'h5E; 4'hE: hex_seg = 7'h79; default: hex_seg = 7'h71;
    endcase
  endfunction

  // Outputs after a step reflect the scan state of the previous cycle (c = cyc-1)
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    load = 1'b0;
  endtask

  task automatic chk(input string tag, input int c, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s @c=%0d: observed %h expected %h", tag, c, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"},  cyc, 16'(ds_en),      16'hF);
    chk({tag, "_seg"}, cyc, 16'(ds_seg),     16'h7F);
    chk({tag, "_dp"},  cyc, 16'(ds_dp),      16'h1);
    chk({tag, "_fd"},  cyc, 16'(frame_done), 16'h0);
  endtask

  // Scan cycles lo..hi-1 with displayed value dd/ddp, brightness b, blanking blz
  task automatic run_range(input int lo, input int hi, input logic [15:0] dd,
                           input logic [3:0] ddp, input logic [3:0] b, input logic blz);
    brightness = b;
    blank_lz   = blz;
    for (int c = lo; c < hi; c++) begin
      int d, p;
      logic lit, blank;
      logic [3:0] e_en;
      logic [6:0] e_seg;
      logic e_dp, e_fd;
      step();
      d = (c / 16) % 4;
      p = c % 16;
      lit   = (b == 4'hF) || (p < int'(b));
      blank = blz && (d > 0) && ((dd >> (4 * d)) == 16'h0);
      e_en  = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg = (lit && !blank) ? ~hex_seg(dd[4*d +: 4]) : 7'h7F;
      e_dp  = lit ? ~ddp[d] : 1'b1;
      e_fd  = (c % 64 == 63);
      chk("ds_en",      c, 16'(ds_en),      16'(e_en));
      chk("ds_seg",     c, 16'(ds_seg),     16'(e_seg));
      chk("ds_dp",      c, 16'(ds_dp),      16'(e_dp));
      chk("frame_done", c, 16'(frame_done), 16'(e_fd));
      if (ds_en != 4'hF) lit_cnt++;
      if (p == 15) begin
        chk("pwm_lit_clocks", c, 16'(lit_cnt), (b == 4'hF) ? 16'd16 : 16'(b));
        lit_cnt = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; dp = '0; brightness = 4'hF; blank_lz = 1'b0;
    step();
    step();
    chk_idle("reset");

    // Release, and stage 12AF in frame 0 so it appears in frame 1
    rst = 1'b0; cyc = 0; lit_cnt = 0;
    data = 16'h12AF; dp = 4'h0; load = 1'b1;
    run_range(0, 64, 16'h0000, 4'h0, 4'hF, 1'b0);
    run_range(64, 128, 16'h12AF, 4'h0, 4'hF, 1'b0);

    // PWM at 4/16, then dark frame while 0070 is staged
    run_range(128, 192, 16'h12AF, 4'h0, 4'h4, 1'b0);
    run_range(192, 200, 16'h12AF, 4'h0, 4'h0, 1'b0);
    data = 16'h0070; dp = 4'b0010; load = 1'b1;
    run_range(200, 256, 16'h12AF, 4'h0, 4'h0, 1'b0);

    // Leading-zero blanking; DP still shown on a blanked digit in the all-zero frame
    run_range(256, 300, 16'h0070, 4'b0010, 4'hF, 1'b1);
    data = 16'h0000; dp = 4'b1000; load = 1'b1;
    run_range(300, 320, 16'h0070, 4'b0010, 4'hF, 1'b1);
    run_range(320, 384, 16'h0000, 4'b1000, 4'hF, 1'b1);

    // Two mid-frame loads: newest wins, shown only from the next frame
    run_range(384, 390, 16'h0000, 4'b1000, 4'hF, 1'b0);
    data = 16'h1111; dp = 4'b0000; load = 1'b1;
    run_range(390, 393, 16'h0000, 4'b1000, 4'hF, 1'b0);
    data = 16'h2222; dp = 4'b0001; load = 1'b1;
    run_range(393, 448, 16'h0000, 4'b1000, 4'hF, 1'b0);

    // Pending 4444 overridden by a load on the boundary cycle itself
    run_range(448, 500, 16'h2222, 4'b0001, 4'hF, 1'b0);
    data = 16'h4444; dp = 4'b0000; load = 1'b1;
    run_range(500, 511, 16'h2222, 4'b0001, 4'hF, 1'b0);
    data = 16'h3333; dp = 4'b0100; load = 1'b1;
    run_range(511, 512, 16'h2222, 4'b0001, 4'hF, 1'b0);

    // Reset during digit 2 with 5555 pending
    run_range(512, 530, 16'h3333, 4'b0100, 4'hF, 1'b0);
    data = 16'h5555; dp = 4'b1111; load = 1'b1;
    run_range(530, 548, 16'h3333, 4'b0100, 4'hF, 1'b0);
    rst = 1'b1;
    step();
    chk_idle("midreset");
    step();
    chk_idle("midreset_hold");
    rst = 1'b0; cyc = 0; lit_cnt = 0;
    run_range(0, 128, 16'h0000, 4'h0, 4'hF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
